// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, LSB first, one bit per clock.
// Start/busy/done handshake; a single borrow flop carries between bits.
module serial_ripple_subtractor #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic             r_bout;
  logic [IW-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic             w_dbit;
  logic             w_brn;
  logic [WIDTH-1:0] w_acc_next;

  assign w_accept = start &&
                    (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_idx == LAST);
  assign w_dbit   = r_a[0] ^ r_b[0] ^ r_br;
  assign w_brn    = (~r_a[0] & r_b[0]) |
                    (~(r_a[0] ^ r_b[0]) & r_br);

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 is at LSB.
  assign w_acc_next = (r_acc >> 1) |
                      (WIDTH'(w_dbit) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_br  <= Bin;
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_brn;
      r_acc <= w_acc_next;
      r_idx <= r_idx + IW'(1);
      if (w_last) begin
        r_d    <= w_acc_next;
        r_bout <= w_brn;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign D    = r_d;
  assign Bout = r_bout;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor at WIDTH 2, 4 and 1.
// Expected values are hand-derived or from a tiny arithmetic model.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] A = '0;
  logic [1:0] B = '0;
  logic       Bin = 1'b0;
  logic       busy, done, Bout;
  logic [1:0] D;

  logic       s4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] d4;

  logic       s1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic       d1;

  serial_ripple_subtractor #(.WIDTH(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .D(D), .Bout(Bout)
  );

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4),
    .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
  );

  serial_ripple_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1),
    .A(a1), .B(b1), .Bin(bin1),
    .busy(busy1), .done(done1), .D(d1), .Bout(bout1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b,
                     input logic bin, input logic [1:0] ed,
                     input logic eb, input string tag);
    int n;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
    n = 0;
    while (!done && n < 8) begin
      if (n < 2) chk({tag, "_busy"}, busy, 1);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_D"}, D, ed);
    chk({tag, "_Bout"}, Bout, eb);
    chk({tag, "_busy_lo"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_D_hold"}, D, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ed, eb2, sa, sb;
    logic [2:0] sum;
    logic [4:0] v;
    logic       eb, sc;
    int         nd, r, n;
    logic       pd;
    logic [1:0] va [3];
    logic [1:0] vb [3];
    logic [1:0] ve [3];

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D", D, 0);
    chk("rst_Bout", Bout, 0);
    @(negedge clk);
    rst = 1'b0;

    op2(2'd3, 2'd1, 1'b0, 2'd2, 1'b0, "d_3m1");
    op2(2'd1, 2'd2, 1'b0, 2'd3, 1'b1, "d_1m2");
    op2(2'd0, 2'd0, 1'b1, 2'd3, 1'b1, "d_0m0b");
    op2(2'd3, 2'd3, 1'b1, 2'd3, 1'b1, "d_3m3b");
    op2(2'd2, 2'd2, 1'b0, 2'd0, 1'b0, "d_eq");

    for (int i = 0; i < 32; i++) begin
      v  = i[4:0];
      sa = v[4:3]; sb = v[2:1]; sc = v[0];
      ed = sa - sb - {1'b0, sc};
      eb = (int'(sa) < int'(sb) + int'(sc));
      op2(sa, sb, sc, ed, eb, "sweep");
    end

    for (int i = 0; i < 32; i++) begin
      v   = i[4:0];
      sa  = v[4:3]; sb = v[2:1]; sc = v[0];
      sum = {1'b0, sa} + {1'b0, sb} + {2'b0, sc};
      if (!sum[2]) op2(sum[1:0], sb, sc, sa, 1'b0, "xchk");
    end

    @(negedge clk);
    A = 2'd3; B = 2'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    A = 2'd0; B = 2'd3; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) begin
        nd++;
        chk("ign_D", D, 2);
        chk("ign_Bout", Bout, 0);
      end
      @(posedge clk); #1;
    end
    chk("ign_ndone", nd, 1);

    va[0] = 2'd2; vb[0] = 2'd1; ve[0] = 2'd1;
    va[1] = 2'd3; vb[1] = 2'd0; ve[1] = 2'd3;
    va[2] = 2'd0; vb[2] = 2'd1; ve[2] = 2'd3;
    @(negedge clk);
    A = va[0]; B = vb[0]; Bin = 1'b0; start = 1'b1;
    r = 0; pd = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (done) begin
        chk("b2b_D", D, ve[r]);
        chk("b2b_single", pd, 0);
        r++;
        if (r < 3) begin
          A = va[r]; B = vb[r];
        end
      end else if (r > 0) begin
        chk("b2b_hold", D, ve[r-1]);
      end
      pd = done;
    end
    start = 1'b0;
    chk("b2b_count", r, 3);
    chk("b2b_Bout", Bout, 1);

    @(negedge clk);
    A = 2'd3; B = 2'd0; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_D", D, 0);
    chk("arst_Bout", Bout, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("arst_nodone", nd, 0);
    op2(2'd2, 2'd3, 1'b0, 2'd3, 1'b1, "post_rst");

    @(negedge clk);
    a4 = 4'd5; b4 = 4'd9; bin4 = 1'b1; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    chk("w4_busy", busy4, 1);
    n = 0;
    while (!done4 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4_lat", n, 4);
    chk("w4_D", d4, 11);
    chk("w4_Bout", bout4, 1);

    @(negedge clk);
    a4 = 4'd9; b4 = 4'd5; bin4 = 1'b0; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    n = 0;
    while (!done4 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4b_lat", n, 4);
    chk("w4b_D", d4, 4);
    chk("w4b_Bout", bout4, 0);

    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    chk("w1_busy", busy1, 1);
    @(posedge clk); #1;
    chk("w1_done", done1, 1);
    chk("w1_D", d1, 1);
    chk("w1_Bout", bout1, 1);

    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b1; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    @(posedge clk); #1;
    chk("w1b_done", done1, 1);
    chk("w1b_D", d1, 0);
    chk("w1b_Bout", bout1, 0);
    @(posedge clk); #1;
    chk("w1b_idle", done1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
